// File: rtl/icache_tag_req_arb_if.sv
// Request/response bundle between the three icache requesters, the tag arbiter and the tag controller.
interface icache_tag_req_arb_if #(
  parameter int ADDR_W   = 32,
  parameter int TXNID_W  = 4,
  parameter int OPCODE_W = 2
);
  logic                dn_req_vld;
  logic                dn_req_rdy;
  logic [ADDR_W-1:0]   dn_req_addr;
  logic [TXNID_W-1:0]  dn_req_txnid;
  logic                up_req_vld;
  logic                up_req_rdy;
  logic [ADDR_W-1:0]   up_req_addr;
  logic [TXNID_W-1:0]  up_req_txnid;
  logic                pf_req_vld;
  logic                pf_req_rdy;
  logic [ADDR_W-1:0]   pf_req_addr;
  logic [TXNID_W-1:0]  pf_req_txnid;
  logic                tag_req_vld;
  logic                tag_req_rdy;
  logic [ADDR_W-1:0]   tag_req_addr;
  logic [OPCODE_W-1:0] tag_req_opcode;
  logic [TXNID_W-1:0]  tag_req_txnid;

  modport slave (
    input  dn_req_vld, dn_req_addr, dn_req_txnid,
    input  up_req_vld, up_req_addr, up_req_txnid,
    input  pf_req_vld, pf_req_addr, pf_req_txnid,
    input  tag_req_rdy,
    output dn_req_rdy, up_req_rdy, pf_req_rdy,
    output tag_req_vld, tag_req_addr, tag_req_opcode, tag_req_txnid
  );

  modport master (
    output dn_req_vld, dn_req_addr, dn_req_txnid,
    output up_req_vld, up_req_addr, up_req_txnid,
    output pf_req_vld, pf_req_addr, pf_req_txnid,
    output tag_req_rdy,
    input  dn_req_rdy, up_req_rdy, pf_req_rdy,
    input  tag_req_vld, tag_req_addr, tag_req_opcode, tag_req_txnid
  );
endinterface

// File: rtl/icache_tag_req_arb.sv
// Tag-array request arbiter: clears every set after reset, then grants dn > up > pf into a one-entry output stage.
// Define ICACHE_TAG_ARB_STARVE_EN to promote prefetch over upstream after STARVE_LIMIT lost grants.
module icache_tag_req_arb #(
  parameter int ICACHE_INDEX_WIDTH      = 6,
  parameter int ADDR_W                  = 32,
  parameter int ICACHE_REQ_TXNID_WIDTH  = 4,
  parameter int ICACHE_REQ_OPCODE_WIDTH = 2,
  parameter logic [ICACHE_REQ_OPCODE_WIDTH-1:0] DOWNSTREAM_OPCODE = 'd1,
  parameter logic [ICACHE_REQ_OPCODE_WIDTH-1:0] UPSTREAM_OPCODE   = 'd2,
  parameter logic [ICACHE_REQ_OPCODE_WIDTH-1:0] PREFETCH_OPCODE   = 'd3,
  parameter int STARVE_LIMIT            = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          stall,
  icache_tag_req_arb_if.slave           bus,
  output logic                          init_wr_en,
  output logic [ICACHE_INDEX_WIDTH-1:0] init_index,
  output logic                          init_done
);
  typedef logic [ADDR_W-1:0]                  req_addr_t;
  typedef logic [ICACHE_REQ_TXNID_WIDTH-1:0]  txnid_t;
  typedef logic [ICACHE_REQ_OPCODE_WIDTH-1:0] opcode_t;
  typedef enum logic {INIT, RUN} state_e;

  localparam logic [ICACHE_INDEX_WIDTH-1:0] IDX_LAST = '1;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve_limit
    $error("STARVE_LIMIT must be in 1..255");
  end

  state_e                        state_q, state_d;
  logic [ICACHE_INDEX_WIDTH-1:0] idx_q, idx_d;
  logic                          vld_p1_q, vld_p1_d;
  req_addr_t                     addr_p1_q, addr_p1_d;
  txnid_t                        txnid_p1_q, txnid_p1_d;
  opcode_t                       op_p1_q, op_p1_d;
  logic                          load, any_vld, pf_promote;
  logic                          gnt_dn, gnt_up, gnt_pf;

`ifdef ICACHE_TAG_ARB_STARVE_EN
  logic [7:0] pf_starve_cnt_q, pf_starve_cnt_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'(STARVE_LIMIT)) ? v : v + 8'd1;
  endfunction

  always_comb begin
    pf_promote      = bus.pf_req_vld && (pf_starve_cnt_q == 8'(STARVE_LIMIT));
    pf_starve_cnt_d = pf_starve_cnt_q;
    if (!bus.pf_req_vld || gnt_pf) pf_starve_cnt_d = '0;
    else if (gnt_up)               pf_starve_cnt_d = sat_inc(pf_starve_cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pf_starve_cnt_q <= '0;
    else        pf_starve_cnt_q <= pf_starve_cnt_d;
  end
`else
  assign pf_promote = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    vld_p1_d   = vld_p1_q;
    addr_p1_d  = addr_p1_q;
    txnid_p1_d = txnid_p1_q;
    op_p1_d    = op_p1_q;
    load       = 1'b0;
    gnt_dn     = 1'b0;
    gnt_up     = 1'b0;
    gnt_pf     = 1'b0;
    any_vld    = bus.dn_req_vld || bus.up_req_vld || bus.pf_req_vld;
    case (state_q)
      INIT: begin
        // index wraps back to 0 on the last set, leaving init_index at 0 in RUN
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) state_d = RUN;
      end
      RUN: begin
        load = (!vld_p1_q || bus.tag_req_rdy) && !stall;
        if (load) begin
          gnt_dn   = bus.dn_req_vld;
          gnt_pf   = !bus.dn_req_vld && (pf_promote || (!bus.up_req_vld && bus.pf_req_vld));
          gnt_up   = !bus.dn_req_vld && !gnt_pf && bus.up_req_vld;
          vld_p1_d = any_vld;
        end
        if (gnt_dn) begin
          addr_p1_d  = bus.dn_req_addr;
          txnid_p1_d = bus.dn_req_txnid;
          op_p1_d    = DOWNSTREAM_OPCODE;
        end else if (gnt_up) begin
          addr_p1_d  = bus.up_req_addr;
          txnid_p1_d = bus.up_req_txnid;
          op_p1_d    = UPSTREAM_OPCODE;
        end else if (gnt_pf) begin
          addr_p1_d  = bus.pf_req_addr;
          txnid_p1_d = bus.pf_req_txnid;
          op_p1_d    = PREFETCH_OPCODE;
        end
      end
      default: ;
    endcase
  end

  // output stage p1: one registered request towards the tag controller
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      idx_q      <= '0;
      vld_p1_q   <= 1'b0;
      addr_p1_q  <= '0;
      txnid_p1_q <= '0;
      op_p1_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      vld_p1_q   <= vld_p1_d;
      addr_p1_q  <= addr_p1_d;
      txnid_p1_q <= txnid_p1_d;
      op_p1_q    <= op_p1_d;
    end
  end

  assign bus.dn_req_rdy     = gnt_dn;
  assign bus.up_req_rdy     = gnt_up;
  assign bus.pf_req_rdy     = gnt_pf;
  assign bus.tag_req_vld    = vld_p1_q;
  assign bus.tag_req_addr   = addr_p1_q;
  assign bus.tag_req_txnid  = txnid_p1_q;
  assign bus.tag_req_opcode = op_p1_q;

  // gated by rst_n so the clear strobe stays low while reset is held
  assign init_wr_en = rst_n && (state_q == INIT);
  assign init_index = idx_q;
  assign init_done  = (state_q == RUN);
endmodule

// File: tb/tb_icache_tag_req_arb.sv
// Bench for icache_tag_req_arb: cycle model checked at every falling edge plus directed literal checks.
module tb_icache_tag_req_arb;
  localparam int IW = 6, AW = 32, TW = 4, OW = 2, LIMIT = 8;
  localparam int SWEEP = 1 << IW;
  localparam logic [OW-1:0] OP_DN = 2'd1, OP_UP = 2'd2, OP_PF = 2'd3;
`ifdef ICACHE_TAG_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall = 1'b0;
  logic          init_wr_en;
  logic [IW-1:0] init_index;
  logic          init_done;

  icache_tag_req_arb_if #(.ADDR_W(AW), .TXNID_W(TW), .OPCODE_W(OW)) bus();

  icache_tag_req_arb #(
    .ICACHE_INDEX_WIDTH(IW), .ADDR_W(AW), .ICACHE_REQ_TXNID_WIDTH(TW),
    .ICACHE_REQ_OPCODE_WIDTH(OW), .DOWNSTREAM_OPCODE(OP_DN),
    .UPSTREAM_OPCODE(OP_UP), .PREFETCH_OPCODE(OP_PF), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .bus(bus),
    .init_wr_en(init_wr_en), .init_index(init_index), .init_done(init_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: cycles since reset release, an output slot, and a lost-grant count for prefetch.
  int            m_n = 0;
  int            m_starve = 0;
  int            m_win;
  logic          m_acc;
  logic          m_init;
  logic          m_vld = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [TW-1:0] m_txn = '0;
  logic [OW-1:0] m_op = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_tag_vld", bus.tag_req_vld, 0);
      chk("rst_tag_addr", bus.tag_req_addr, 0);
      chk("rst_tag_op", bus.tag_req_opcode, 0);
      chk("rst_tag_txn", bus.tag_req_txnid, 0);
      chk("rst_init_wr_en", init_wr_en, 0);
      chk("rst_init_index", init_index, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_rdys", {bus.dn_req_rdy, bus.up_req_rdy, bus.pf_req_rdy}, 0);
      m_n = 0; m_starve = 0; m_vld = 1'b0;
      m_addr = '0; m_txn = '0; m_op = '0;
    end else begin
      m_init = (m_n < SWEEP);
      chk("init_wr_en", init_wr_en, m_init);
      chk("init_index", init_index, m_init ? m_n : 0);
      chk("init_done", init_done, !m_init);
      m_acc = !m_init && (!m_vld || bus.tag_req_rdy) && !stall;
      m_win = 0;
      if (m_acc) begin
        if (bus.dn_req_vld) m_win = 1;
        else if (STARVE_ON && bus.pf_req_vld && m_starve >= LIMIT) m_win = 3;
        else if (bus.up_req_vld) m_win = 2;
        else if (bus.pf_req_vld) m_win = 3;
      end
      chk("dn_rdy", bus.dn_req_rdy, m_win == 1);
      chk("up_rdy", bus.up_req_rdy, m_win == 2);
      chk("pf_rdy", bus.pf_req_rdy, m_win == 3);
      chk("tag_vld", bus.tag_req_vld, m_vld);
      if (m_vld) begin
        chk("tag_addr", bus.tag_req_addr, m_addr);
        chk("tag_txn", bus.tag_req_txnid, m_txn);
        chk("tag_op", bus.tag_req_opcode, m_op);
      end
      if (m_acc) begin
        m_vld = (m_win != 0);
        case (m_win)
          1: begin m_addr = bus.dn_req_addr; m_txn = bus.dn_req_txnid; m_op = OP_DN; end
          2: begin m_addr = bus.up_req_addr; m_txn = bus.up_req_txnid; m_op = OP_UP; end
          3: begin m_addr = bus.pf_req_addr; m_txn = bus.pf_req_txnid; m_op = OP_PF; end
          default: ;
        endcase
      end
      if (!bus.pf_req_vld || m_win == 3) m_starve = 0;
      else if (m_win == 2 && m_starve < LIMIT) m_starve++;
      if (m_n < SWEEP) m_n++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.dn_req_vld = 1'b0; bus.dn_req_addr = 32'h0000_D0D0; bus.dn_req_txnid = 4'd1;
    bus.up_req_vld = 1'b0; bus.up_req_addr = 32'h0000_A0A0; bus.up_req_txnid = 4'd2;
    bus.pf_req_vld = 1'b0; bus.pf_req_addr = 32'h0000_F0F0; bus.pf_req_txnid = 4'd3;
    bus.tag_req_rdy = 1'b1;
    tick(); tick();
    // reset sweep with all requesters already valid
    bus.dn_req_vld = 1'b1; bus.up_req_vld = 1'b1; bus.pf_req_vld = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < SWEEP; i++) begin
      @(negedge clk);
      chk("sweep_index", init_index, i);
      chk("sweep_wr_en", init_wr_en, 1);
      chk("sweep_rdys", {bus.dn_req_rdy, bus.up_req_rdy, bus.pf_req_rdy}, 0);
    end
    // three-way collision: first grant on the cycle init_done rises
    @(negedge clk);
    chk("col_done", init_done, 1);
    chk("col_wr_en", init_wr_en, 0);
    chk("col_dn_rdy", bus.dn_req_rdy, 1);
    tick(); bus.dn_req_vld = 1'b0;
    @(negedge clk);
    chk("col_op_dn", bus.tag_req_opcode, OP_DN);
    chk("col_up_rdy", bus.up_req_rdy, 1);
    tick(); bus.up_req_vld = 1'b0;
    @(negedge clk);
    chk("col_op_up", bus.tag_req_opcode, OP_UP);
    chk("col_pf_rdy", bus.pf_req_rdy, 1);
    tick(); bus.pf_req_vld = 1'b0;
    @(negedge clk);
    chk("col_op_pf", bus.tag_req_opcode, OP_PF);
    chk("col_pf_addr", bus.tag_req_addr, 32'h0000_F0F0);
    tick();
    @(negedge clk);
    chk("col_idle", bus.tag_req_vld, 0);

    // backpressure with upstream txnid 5 held in the output stage
    tick();
    bus.tag_req_rdy = 1'b0; bus.up_req_vld = 1'b1; bus.up_req_txnid = 4'd5;
    @(negedge clk);
    chk("bp_up_rdy", bus.up_req_rdy, 1);
    tick();
    bus.up_req_vld = 1'b0; bus.dn_req_vld = 1'b1; bus.dn_req_txnid = 4'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_txn", bus.tag_req_txnid, 5);
      chk("bp_hold_vld", bus.tag_req_vld, 1);
      chk("bp_dn_rdy", bus.dn_req_rdy, 0);
    end
    tick(); bus.tag_req_rdy = 1'b1;
    @(negedge clk);
    chk("bp_release_dn_rdy", bus.dn_req_rdy, 1);
    tick(); bus.dn_req_vld = 1'b0;
    @(negedge clk);
    chk("bp_next_txn", bus.tag_req_txnid, 9);
    chk("bp_next_op", bus.tag_req_opcode, OP_DN);
    tick();
    @(negedge clk);

    // stall with empty output, then stall rising over a pending output
    tick();
    stall = 1'b1; bus.up_req_vld = 1'b1; bus.up_req_txnid = 4'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_up_rdy", bus.up_req_rdy, 0);
      chk("stall_tag_vld", bus.tag_req_vld, 0);
    end
    tick(); stall = 1'b0;
    @(negedge clk);
    chk("unstall_up_rdy", bus.up_req_rdy, 1);
    tick();
    bus.up_req_vld = 1'b0; stall = 1'b1; bus.pf_req_vld = 1'b1; bus.pf_req_txnid = 4'd4;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stall_hold_txn", bus.tag_req_txnid, 3);
      chk("stall_hold_vld", bus.tag_req_vld, 1);
      chk("stall_pf_rdy", bus.pf_req_rdy, 0);
    end
    tick(); stall = 1'b0;
    @(negedge clk);
    chk("unstall_pf_rdy", bus.pf_req_rdy, 1);
    tick(); bus.pf_req_vld = 1'b0;
    @(negedge clk);
    chk("stall_pf_txn", bus.tag_req_txnid, 4);
    tick();
    @(negedge clk);

    // starvation: upstream and prefetch held continuously
    tick();
    bus.up_req_vld = 1'b1; bus.up_req_txnid = 4'd6;
    bus.pf_req_vld = 1'b1; bus.pf_req_txnid = 4'd7;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("starve_up_rdy", bus.up_req_rdy, !(STARVE_ON && k == 9));
      chk("starve_pf_rdy", bus.pf_req_rdy, STARVE_ON && k == 9);
    end
    tick(); bus.up_req_vld = 1'b0; bus.pf_req_vld = 1'b0;
    @(negedge clk);

    // reset mid-operation with a request in the output stage
    tick(); bus.up_req_vld = 1'b1; bus.up_req_txnid = 4'd8;
    @(negedge clk);
    chk("mid_up_rdy", bus.up_req_rdy, 1);
    tick(); bus.up_req_vld = 1'b0;
    chk("mid_pre_vld", bus.tag_req_vld, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_async_vld", bus.tag_req_vld, 0);
    chk("mid_async_index", init_index, 0);
    chk("mid_async_wr_en", init_wr_en, 0);
    tick(); rst_n = 1'b1;
    @(negedge clk);
    chk("mid_sweep_idx0", init_index, 0);
    chk("mid_sweep_wr_en", init_wr_en, 1);
    @(negedge clk);
    chk("mid_sweep_idx1", init_index, 1);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/icache_tag_req_arb.md
# icache_tag_req_arb

Arbiter and sequencer in front of the icache tag-array controller. It clears every tag-array set after reset, then shares the single tag-array request port between three requesters: downstream (invalidate/snoop), upstream (fetch) and prefetch. Each winning request is driven through a one-entry registered output stage with valid/ready semantics, and that stage honours the pipeline `stall`.

## Interface
- `STARVE_LIMIT`, 8: consecutive lost prefetch arbitrations before prefetch is promoted above upstream. Range 1..255.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `dn_req_vld` / `dn_req_rdy` in / out 1: downstream request handshake.
- `dn_req_addr` in `req_addr_t`: downstream address.
- `dn_req_txnid` in `ICACHE_REQ_TXNID_WIDTH`: downstream transaction id.
- `up_req_vld` / `up_req_rdy` in / out 1: upstream fetch handshake.
- `up_req_addr` in `req_addr_t`: upstream address.
- `up_req_txnid` in `ICACHE_REQ_TXNID_WIDTH`: upstream transaction id.
- `pf_req_vld` / `pf_req_rdy` in / out 1: prefetch handshake.
- `pf_req_addr` in `req_addr_t`: prefetch address.
- `pf_req_txnid` in `ICACHE_REQ_TXNID_WIDTH`: prefetch transaction id.
- `tag_req_vld` out 1: request to the tag controller, registered.
- `tag_req_rdy` in 1: the tag controller accepts.
- `tag_req_addr` out `req_addr_t`: registered address.
- `tag_req_opcode` out `ICACHE_REQ_OPCODE_WIDTH`: one of `DOWNSTREAM_OPCODE`, `UPSTREAM_OPCODE`, `PREFETCH_OPCODE`.
- `tag_req_txnid` out `ICACHE_REQ_TXNID_WIDTH`: registered transaction id.
- `init_wr_en` out 1: tag-array clear write strobe.
- `init_index` out `ICACHE_INDEX_WIDTH`: set index being cleared.
- `init_done` out 1: high once the clear sweep has completed.
- `stall` in 1: pipeline stall. While high, no grant and no output load.

## Operation
- **FSM states:** `INIT`, `RUN`. Reset enters `INIT`.
- **INIT**
  - `init_wr_en` = 1 every cycle; `init_index` counts 0 .. 2^`ICACHE_INDEX_WIDTH`-1, one set per cycle.
  - The sweep ignores `stall`.
  - After the last index: `init_wr_en` = 0, `init_done` = 1 on the next cycle, and the FSM moves to `RUN`.
  - All `*_req_rdy` = 0 in `INIT`.
- **RUN**
  - Load condition: `load = (!tag_req_vld || tag_req_rdy) && !stall`.
  - When `load` is true and at least one request is valid, exactly one winner is chosen.
  - The winner's `*_rdy` = 1 combinationally in that same cycle.
  - The winner's addr/txnid/opcode are registered into the output stage, and `tag_req_vld` = 1 next cycle.
  - When `load` is true with no valid requester, `tag_req_vld` clears to 0.
- **Priority:** downstream > upstream > prefetch.
- **Output hold:** while `tag_req_vld && !tag_req_rdy`, or while `stall` = 1, the output registers hold and all `rdy` = 0.
- **Starvation counter `pf_starve_cnt`** (8-bit, saturates at `STARVE_LIMIT`):
  - Increments on each grant to upstream while `pf_req_vld` = 1.
  - Clears on a prefetch grant, or in any cycle with `pf_req_vld` = 0.

## Timing
- **Reset values:**
  - `tag_req_vld` = 0; `tag_req_addr`, `tag_req_opcode`, `tag_req_txnid` = 0.
  - `init_wr_en` = 0 during reset, then 1 in the first cycle after deassertion.
  - `init_index` = 0; `init_done` = 0.
  - All `*_rdy` = 0; `pf_starve_cnt` = 0.
- **Clear sweep:** lasts 2^`ICACHE_INDEX_WIDTH` cycles. The first grant is possible on the cycle `init_done` rises.
- **Latency:** request accept to `tag_req_vld` is 1 cycle.
- **Throughput:** one request per cycle when `tag_req_rdy` is held at 1.
- **Simultaneous events:**
  - `stall` rising with a pending output: the output is held and no grant is made.
  - A request valid that is not granted must stay asserted; the arbiter keeps no internal memory of it.
- **Reset mid-operation:** reset asserted during `INIT` or `RUN` drops any in-flight output request, clears the counter, and restarts the sweep at index 0.

## Configuration
- `ICACHE_TAG_ARB_STARVE_EN` defined:
  - When `pf_starve_cnt` == `STARVE_LIMIT` and `pf_req_vld` = 1, prefetch beats upstream for one grant.
  - Downstream still wins over both.
  - The counter clears after that grant.
- Macro undefined:
  - Pure fixed priority; prefetch can starve indefinitely.
  - `pf_starve_cnt` is not instantiated.

## Test plan
- **Reset sweep, `ICACHE_INDEX_WIDTH` = 6:** `init_index` steps 0..63 over 64 cycles with `init_wr_en` = 1. `init_done` = 1 at cycle 65. All `rdy` = 0 throughout, even with all three requesters valid.
- **Three-way collision:** all three valid in the same cycle with `tag_req_rdy` = 1. Grants are downstream, then upstream, then prefetch on consecutive cycles. Opcodes appear one cycle after each grant.
- **Backpressure:** `tag_req_rdy` = 0 for 3 cycles with an upstream request (txnid 5) loaded. `tag_req_*` stay stable and all `rdy` = 0. `tag_req_rdy` = 1 then releases the next grant in the same cycle.
- **Stall:** `stall` = 1 for 4 cycles with `up_req_vld` = 1 and the output empty. No `up_req_rdy` and `tag_req_vld` stays 0. Grant occurs in the first cycle `stall` = 0.
- **Starvation guard, `STARVE_LIMIT` = 8, macro on:** `up_req_vld` and `pf_req_vld` held at 1 continuously. Prefetch wins the 9th grant, then upstream resumes. With the macro off, prefetch never wins.
- **Reset mid-operation:** `rst_n` pulsed low while `tag_req_vld` = 1. `tag_req_vld` drops to 0 asynchronously, and the sweep restarts at index 0.
